// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Fetch-and-sequence controller for a 256 x 64-bit microcode EPROM. Selects
//   the EPROM, waits out its asynchronous access time, latches the microword,
//   presents it to the datapath and computes the next microaddress
//   (increment, jump, conditional branch, call/return, halt).
//
// Build option:
//   MC_STACK_EN  defined   -> CALL/RET use a STACK_DEPTH-entry return stack,
//                             overflow/underflow raise the sticky fault flag.
//                undefined -> no stack; CALL acts as JMP, RET acts as INC,
//                             fault is tied low.
//
// Parameters:
//   WAIT_CYCLES  cycles the EPROM is held selected before data is sampled (1..255)
//   STACK_DEPTH  return-stack entries, power of two (2..16)
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   dispatch_valid/addr/ready    start-of-routine handshake (accepted only when idle)
//   stall                        datapath holds the current microword
//   cond[7:0]                    datapath condition flags
//   _cs, _oe, addr[7:0]          EPROM chip select / output enable (active low), address
//   data[63:0]                   EPROM data
//   uword[63:0], uword_valid     latched microword and its executing flag
//   busy                         sequencer is not idle
//   fault                        sticky stack overflow/underflow flag
module microcode_sequencer #(
  parameter int WAIT_CYCLES = 9,
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dispatch_valid,
  input  logic [7:0]  dispatch_addr,
  output logic        dispatch_ready,
  input  logic        stall,
  input  logic [7:0]  cond,
  output logic        _cs,
  output logic        _oe,
  output logic [7:0]  addr,
  input  logic [63:0] data,
  output logic [63:0] uword,
  output logic        uword_valid,
  output logic        busy,
  output logic        fault
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("microcode_sequencer: WAIT_CYCLES must be 1..255");
  end
  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("microcode_sequencer: STACK_DEPTH must be a power of two, 2..16");
  end

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  localparam logic [7:0] LAST_CNT = 8'(WAIT_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;

  // Microword fields: next-op, condition select, branch target.
  logic [2:0] op;
  logic       c;
  logic [7:0] tgt;
  logic [7:0] seq_addr;
  logic [7:0] nxt_addr;
  logic       go_idle;

  function automatic logic [7:0] inc8(input logic [7:0] a);
    return a + 8'd1;
  endfunction

  assign op       = uword[63:61];
  assign c        = cond[uword[60:58]];
  assign tgt      = uword[57:50];
  assign seq_addr = inc8(addr);

`ifdef MC_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  // sp counts entries; sp == STACK_DEPTH means full, so it needs one extra bit.
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;
  logic [7:0]      stack [STACK_DEPTH];
  logic            push;
  logic            pop;
  logic            set_fault;

  assign sp_m1 = sp - SP_W'(1);
`else
  assign fault = 1'b0;
`endif

  // Next-address decode; only consumed on the edge that leaves EXEC.
  always_comb begin
    nxt_addr = seq_addr;
    go_idle  = 1'b0;
`ifdef MC_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
    set_fault = 1'b0;
`endif
    case (op)
      3'b001: nxt_addr = tgt;
      3'b010: if (c)  nxt_addr = tgt;
      3'b011: if (!c) nxt_addr = tgt;
`ifdef MC_STACK_EN
      3'b100: begin
        if (sp == SP_FULL) begin
          go_idle   = 1'b1;
          set_fault = 1'b1;
        end else begin
          push     = 1'b1;
          nxt_addr = tgt;
        end
      end
      3'b101: begin
        if (sp == '0) begin
          go_idle   = 1'b1;
          set_fault = 1'b1;
        end else begin
          pop      = 1'b1;
          nxt_addr = stack[sp_m1[SP_W-2:0]];
        end
      end
`else
      3'b100: nxt_addr = tgt;
`endif
      3'b110: go_idle = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_STACK_EN
  // Return-address storage carries no reset; sp alone defines its contents.
  always_ff @(posedge clk) begin
    if (state == EXEC && !stall && push)
      stack[sp[SP_W-2:0]] <= seq_addr;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      _cs            <= 1'b1;
      _oe            <= 1'b1;
      addr           <= '0;
      uword          <= '0;
      uword_valid    <= 1'b0;
      busy           <= 1'b0;
      dispatch_ready <= 1'b1;
`ifdef MC_STACK_EN
      sp             <= '0;
      fault          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dispatch_valid) begin
            state          <= FETCH;
            addr           <= dispatch_addr;
            cnt            <= '0;
            _cs            <= 1'b0;
            _oe            <= 1'b0;
            busy           <= 1'b1;
            dispatch_ready <= 1'b0;
`ifdef MC_STACK_EN
            sp             <= '0;
            fault          <= 1'b0;
`endif
          end
        end
        FETCH: begin
          // EPROM data is sampled on the edge ending the last wait cycle.
          if (cnt == LAST_CNT) begin
            state       <= EXEC;
            uword       <= data;
            uword_valid <= 1'b1;
            _cs         <= 1'b1;
            _oe         <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EXEC: begin
          if (!stall) begin
            uword_valid <= 1'b0;
            if (go_idle) begin
              state          <= IDLE;
              busy           <= 1'b0;
              dispatch_ready <= 1'b1;
            end else begin
              state <= FETCH;
              addr  <= nxt_addr;
              cnt   <= '0;
              _cs   <= 1'b0;
              _oe   <= 1'b0;
            end
`ifdef MC_STACK_EN
            if (set_fault) fault <= 1'b1;
            if (push)      sp    <= sp + SP_W'(1);
            if (pop)       sp    <= sp_m1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus
// randomized microprograms checked against a program-level reference model.
module tb_microcode_sequencer;

  localparam int W     = 9;
  localparam int DEPTH = 4;
`ifdef MC_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  localparam logic [2:0] OP_INC = 3'd0, OP_JMP = 3'd1, OP_BRT = 3'd2, OP_BRF = 3'd3,
                         OP_CALL = 3'd4, OP_RET = 3'd5, OP_HALT = 3'd6;

  logic        clk;
  logic        reset;
  logic        dispatch_valid;
  logic [7:0]  dispatch_addr;
  logic        dispatch_ready;
  logic        stall;
  logic [7:0]  cond;
  logic        _cs;
  logic        _oe;
  logic [7:0]  addr;
  logic [63:0] data;
  logic [63:0] uword;
  logic        uword_valid;
  logic        busy;
  logic        fault;

  logic [63:0] rom [256];
  int          sel_cyc;
  logic [7:0]  mstk [$];

  int tests_run    = 0;
  int tests_failed = 0;

  microcode_sequencer #(.WAIT_CYCLES(W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_addr(dispatch_addr),
    .dispatch_ready(dispatch_ready), .stall(stall), .cond(cond),
    ._cs(_cs), ._oe(_oe), .addr(addr), .data(data),
    .uword(uword), .uword_valid(uword_valid), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EPROM model: data becomes valid only after W-1 full selected cycles,
  // so sampling even one edge early picks up the junk pattern.
  always @(posedge clk) sel_cyc <= _cs ? 0 : sel_cyc + 1;
  assign data = (!_cs && !_oe && sel_cyc >= W - 1) ? rom[addr]
                                                     : ({8{addr}} ^ 64'hA5A5_5A5A_C3C3_3C3C);

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] mk(input logic [2:0] op, input logic [2:0] sel,
                                     input logic [7:0] t);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {op, sel, t, r[49:0]};
  endfunction

  // Program-level reference: next microaddress, halt and fault from one microword.
  task automatic model_next(input logic [63:0] w, input logic [7:0] pc, input logic [7:0] cnd,
                            output logic [7:0] npc, output bit idle, output bit flt);
    int op, sel, t, nseq;
    bit c;
    op = int'(w[63:61]); sel = int'(w[60:58]); t = int'(w[57:50]);
    c = cnd[sel];
    nseq = (int'(pc) + 1) % 256;
    idle = 1'b0; flt = 1'b0; npc = 8'(nseq);
    case (op)
      1: npc = 8'(t);
      2: if (c) npc = 8'(t);
      3: if (!c) npc = 8'(t);
      4: begin
        if (!STACK_EN) npc = 8'(t);
        else if (mstk.size() >= DEPTH) begin idle = 1'b1; flt = 1'b1; npc = pc; end
        else begin mstk.push_back(8'(nseq)); npc = 8'(t); end
      end
      5: begin
        if (STACK_EN) begin
          if (mstk.size() == 0) begin idle = 1'b1; flt = 1'b1; npc = pc; end
          else npc = mstk.pop_back();
        end
      end
      6: begin idle = 1'b1; npc = pc; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; dispatch_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mstk.delete();
  endtask

  // Leaves the bench at the negedge following the accepting edge.
  task automatic do_dispatch(input logic [7:0] a);
    @(negedge clk);
    dispatch_valid = 1'b1; dispatch_addr = a;
    @(negedge clk);
    dispatch_valid = 1'b0;
  endtask

  // Counts cycles with _cs low starting at the current negedge; stops at the
  // first negedge with _cs high (bounded).
  task automatic observe_fetch(output int len, output logic [7:0] a, output bit stable);
    len = 0; a = addr; stable = 1'b1;
    while (_cs === 1'b0 && len < 400) begin
      if (addr !== a || _oe !== 1'b0) stable = 1'b0;
      len++;
      @(negedge clk);
    end
  endtask

  // Holds stall for k cycles (cond scrambled meanwhile), then releases with cnd.
  task automatic step_exec(input int k, input logic [7:0] cnd, output bit held);
    logic [63:0] w0;
    w0 = uword; held = 1'b1;
    if (k > 0) stall = 1'b1;
    for (int i = 0; i < k; i++) begin
      cond = 8'($urandom);
      @(negedge clk);
      if (uword !== w0 || _cs !== 1'b1 || uword_valid !== 1'b1) held = 1'b0;
    end
    stall = 1'b0; cond = cnd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (_cs !== 1'b1) begin tests_failed++; $display("FAIL reset_cs act=%b exp=1", _cs); end
    tests_run++; if (_oe !== 1'b1) begin tests_failed++; $display("FAIL reset_oe act=%b exp=1", _oe); end
    tests_run++; if (addr !== 8'h00) begin tests_failed++; $display("FAIL reset_addr act=%h exp=00", addr); end
    tests_run++; if (uword !== 64'h0) begin tests_failed++; $display("FAIL reset_uword act=%h exp=0", uword); end
    tests_run++; if (uword_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_uvalid act=%b exp=0", uword_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy act=%b exp=0", busy); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault act=%b exp=0", fault); end
    tests_run++; if (dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready act=%b exp=1", dispatch_ready); end
  endtask

  task automatic test_dispatch_fetch();
    int len; logic [7:0] fa; bit stable, held;
    rom[8'h10] = mk(OP_INC, 3'd0, 8'h00);
    rom[8'h11] = mk(OP_HALT, 3'd0, 8'h00);
    do_reset();
    do_dispatch(8'h10);
    dispatch_valid = 1'b1; dispatch_addr = 8'h77;   // must be ignored while busy
    observe_fetch(len, fa, stable);
    tests_run++; if (len !== W) begin tests_failed++; $display("FAIL df_len act=%0d exp=%0d", len, W); end
    tests_run++; if (fa !== 8'h10) begin tests_failed++; $display("FAIL df_addr act=%h exp=10", fa); end
    tests_run++; if (stable !== 1'b1) begin tests_failed++; $display("FAIL df_addr_stable act=%b exp=1", stable); end
    tests_run++; if (uword !== rom[8'h10]) begin tests_failed++; $display("FAIL df_uword act=%h exp=%h", uword, rom[8'h10]); end
    tests_run++; if (uword_valid !== 1'b1) begin tests_failed++; $display("FAIL df_uvalid act=%b exp=1", uword_valid); end
    tests_run++; if (dispatch_ready !== 1'b0) begin tests_failed++; $display("FAIL df_ready_busy act=%b exp=0", dispatch_ready); end
    dispatch_valid = 1'b0;
    step_exec(0, 8'h00, held);
    observe_fetch(len, fa, stable);
    tests_run++; if (fa !== 8'h11) begin tests_failed++; $display("FAIL df_next_addr act=%h exp=11", fa); end
    tests_run++; if (len !== W) begin tests_failed++; $display("FAIL df_next_len act=%0d exp=%0d", len, W); end
    step_exec(0, 8'h00, held);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL df_halt_busy act=%b exp=0", busy); end
    tests_run++; if (dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL df_halt_ready act=%b exp=1", dispatch_ready); end
    tests_run++; if (addr !== 8'h11) begin tests_failed++; $display("FAIL df_halt_addr act=%h exp=11", addr); end
  endtask

  task automatic test_branch();
    int len; logic [7:0] fa; bit stable, held;
    logic [7:0] starts [4] = '{8'h30, 8'h30, 8'h32, 8'h32};
    logic [7:0] conds  [4] = '{8'h08, 8'hF7, 8'h08, 8'hF7};
    logic [7:0] exps   [4] = '{8'h40, 8'h31, 8'h33, 8'h40};
    rom[8'h30] = mk(OP_BRT, 3'd3, 8'h40);
    rom[8'h32] = mk(OP_BRF, 3'd3, 8'h40);
    for (int i = 0; i < 4; i++) begin
      do_reset();
      do_dispatch(starts[i]);
      observe_fetch(len, fa, stable);
      step_exec(0, conds[i], held);
      observe_fetch(len, fa, stable);
      tests_run++; if (fa !== exps[i]) begin tests_failed++; $display("FAIL branch_%0d act=%h exp=%h", i, fa, exps[i]); end
    end
    do_reset();
  endtask

  task automatic test_stall();
    int len; logic [7:0] fa; bit stable, held;
    rom[8'h50] = mk(OP_JMP, 3'd0, 8'h60);
    rom[8'h60] = mk(OP_HALT, 3'd0, 8'h00);
    do_reset();
    do_dispatch(8'h50);
    observe_fetch(len, fa, stable);
    step_exec(5, 8'h00, held);
    tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL stall_hold act=%b exp=1", held); end
    tests_run++; if (_cs !== 1'b0) begin tests_failed++; $display("FAIL stall_refetch_cs act=%b exp=0", _cs); end
    observe_fetch(len, fa, stable);
    tests_run++; if (fa !== 8'h60) begin tests_failed++; $display("FAIL stall_next_addr act=%h exp=60", fa); end
    tests_run++; if (len !== W) begin tests_failed++; $display("FAIL stall_next_len act=%0d exp=%0d", len, W); end
    step_exec(0, 8'h00, held);
  endtask

  task automatic test_wrap_halt();
    int len; logic [7:0] fa; bit stable, held;
    rom[8'hFF] = mk(OP_INC, 3'd0, 8'h00);
    rom[8'h00] = mk(OP_HALT, 3'd0, 8'h00);
    do_reset();
    do_dispatch(8'hFF);
    observe_fetch(len, fa, stable);
    step_exec(0, 8'h00, held);
    observe_fetch(len, fa, stable);
    tests_run++; if (fa !== 8'h00) begin tests_failed++; $display("FAIL wrap_addr act=%h exp=00", fa); end
    step_exec(0, 8'h00, held);
    tests_run++; if (dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL halt_ready act=%b exp=1", dispatch_ready); end
    tests_run++; if (_cs !== 1'b1) begin tests_failed++; $display("FAIL halt_cs act=%b exp=1", _cs); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL halt_busy act=%b exp=0", busy); end
  endtask

  task automatic test_call_ret();
    int len; logic [7:0] fa; bit stable, held;
    logic [7:0] exp_ret;
    exp_ret = STACK_EN ? 8'h21 : 8'h51;
    rom[8'h20] = mk(OP_CALL, 3'd0, 8'h50);
    rom[8'h50] = mk(OP_RET, 3'd0, 8'h00);
    rom[8'h21] = mk(OP_HALT, 3'd0, 8'h00);
    rom[8'h51] = mk(OP_HALT, 3'd0, 8'h00);
    for (int i = 0; i < 5; i++) rom[8'h60 + i] = mk(OP_CALL, 3'd0, 8'(8'h61 + i));
    rom[8'h65] = mk(OP_HALT, 3'd0, 8'h00);
    rom[8'h70] = mk(OP_RET, 3'd0, 8'h00);
    rom[8'h71] = mk(OP_HALT, 3'd0, 8'h00);
    do_reset();
    do_dispatch(8'h20);
    observe_fetch(len, fa, stable);
    step_exec(0, 8'h00, held);
    observe_fetch(len, fa, stable);
    tests_run++; if (fa !== 8'h50) begin tests_failed++; $display("FAIL call_target act=%h exp=50", fa); end
    step_exec(1, 8'h00, held);
    observe_fetch(len, fa, stable);
    tests_run++; if (fa !== exp_ret) begin tests_failed++; $display("FAIL ret_addr act=%h exp=%h", fa, exp_ret); end
    step_exec(0, 8'h00, held);
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL callret_fault act=%b exp=0", fault); end
    // Nested calls: the fifth overflows a 4-deep stack.
    do_dispatch(8'h60);
    for (int i = 0; i < 5; i++) begin
      observe_fetch(len, fa, stable);
      tests_run++; if (fa !== 8'(8'h60 + i)) begin tests_failed++; $display("FAIL nest_addr_%0d act=%h exp=%h", i, fa, 8'(8'h60 + i)); end
      step_exec(0, 8'h00, held);
    end
`ifdef MC_STACK_EN
    tests_run++; if (fault !== 1'b1) begin tests_failed++; $display("FAIL overflow_fault act=%b exp=1", fault); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL overflow_busy act=%b exp=0", busy); end
`else
    observe_fetch(len, fa, stable);
    tests_run++; if (fa !== 8'h65) begin tests_failed++; $display("FAIL nostack_call_addr act=%h exp=65", fa); end
    step_exec(0, 8'h00, held);
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL nostack_fault act=%b exp=0", fault); end
`endif
    do_dispatch(8'h65);
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL dispatch_clears_fault act=%b exp=0", fault); end
    observe_fetch(len, fa, stable);
    step_exec(0, 8'h00, held);
    // RET with nothing pushed.
    do_dispatch(8'h70);
    observe_fetch(len, fa, stable);
    step_exec(0, 8'h00, held);
`ifdef MC_STACK_EN
    tests_run++; if (fault !== 1'b1) begin tests_failed++; $display("FAIL underflow_fault act=%b exp=1", fault); end
    tests_run++; if (dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL underflow_ready act=%b exp=1", dispatch_ready); end
`else
    tests_run++; if (addr !== 8'h71) begin tests_failed++; $display("FAIL nostack_ret_addr act=%h exp=71", addr); end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    do_dispatch(8'h35);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (_cs !== 1'b1) begin tests_failed++; $display("FAIL midrst_cs act=%b exp=1", _cs); end
    tests_run++; if (_oe !== 1'b1) begin tests_failed++; $display("FAIL midrst_oe act=%b exp=1", _oe); end
    tests_run++; if (addr !== 8'h00) begin tests_failed++; $display("FAIL midrst_addr act=%h exp=00", addr); end
    tests_run++; if (uword_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_uvalid act=%b exp=0", uword_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy act=%b exp=0", busy); end
  endtask

  task automatic test_random_programs();
    int len, k; logic [7:0] fa, pc, npc, cnd; bit stable, held, idle, flt, ended;
    for (int p = 0; p < 25; p++) begin
      for (int a = 0; a < 256; a++)
        rom[a] = mk(3'($urandom_range(0, 7)), 3'($urandom), 8'($urandom));
      do_reset();
      pc = 8'($urandom);
      do_dispatch(pc);
      ended = 1'b0;
      for (int s = 0; s < 40 && !ended; s++) begin
        observe_fetch(len, fa, stable);
        tests_run++; if (fa !== pc) begin tests_failed++; $display("FAIL rnd_addr p%0d s%0d act=%h exp=%h", p, s, fa, pc); end
        tests_run++; if (len !== W || !stable) begin tests_failed++; $display("FAIL rnd_fetch p%0d s%0d len=%0d stable=%b exp_len=%0d", p, s, len, stable, W); end
        tests_run++; if (uword !== rom[pc] || uword_valid !== 1'b1) begin tests_failed++; $display("FAIL rnd_uword p%0d s%0d act=%h exp=%h", p, s, uword, rom[pc]); end
        k = $urandom_range(0, 3);
        cnd = 8'($urandom);
        step_exec(k, cnd, held);
        tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL rnd_stall p%0d s%0d act=%b exp=1", p, s, held); end
        model_next(rom[pc], pc, cnd, npc, idle, flt);
        if (idle) begin
          ended = 1'b1;
          tests_run++; if (busy !== 1'b0 || dispatch_ready !== 1'b1 || fault !== flt) begin
            tests_failed++; $display("FAIL rnd_end p%0d busy=%b ready=%b fault=%b exp_fault=%b", p, busy, dispatch_ready, fault, flt);
          end
        end
        pc = npc;
      end
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b0; dispatch_valid = 1'b0; dispatch_addr = 8'h00;
    stall = 1'b0; cond = 8'h00;
    for (int a = 0; a < 256; a++) rom[a] = 64'h0;
    test_reset();
    test_dispatch_fetch();
    test_branch();
    test_stall();
    test_wrap_halt();
    test_call_ret();
    test_reset_mid_fetch();
    test_random_programs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
